// File: rtl/test_sequencer_pkg.sv
// Shared opcodes, error codes, FSM states and operand-count decode for the test sequencer.
package test_sequencer_pkg;

    typedef enum logic [2:0] {
        OpNone     = 3'd0,
        OpSet      = 3'd1,
        OpWait     = 3'd2,
        OpPause    = 3'd3,
        OpWin      = 3'd4,
        OpFail     = 3'd5,
        OpJump     = 3'd6,
        OpWaitMask = 3'd7
    } opcodeT;

    typedef enum logic [2:0] {
        ErrNone     = 3'd0,
        ErrTimeout  = 3'd1,
        ErrOpcode   = 3'd2,
        ErrBus      = 3'd3,
        ErrExplicit = 3'd4,
        ErrRange    = 3'd5
    } errCodeT;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StOperand,
        StExec,
        StPoll,
        StDelay,
        StPass,
        StFail
    } stateT;

    localparam int unsigned MaxOperands = 4;

    function automatic logic [2:0] operandCount(input opcodeT opcode);
        case (opcode)
            OpSet:      operandCount = 3'd2;
            OpWait:     operandCount = 3'd4;
            OpPause:    operandCount = 3'd1;
            OpJump:     operandCount = 3'd1;
            OpWaitMask: operandCount = 3'd4;
            default:    operandCount = 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/timeout_timer.sv
// Prescaled saturating tick counter used to bound POLL and DELAY.
module timeout_timer #(
    parameter int unsigned TIMEOUT_DIV = 0,
    parameter int unsigned DATA_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rstN,
    input  logic                  clear,
    input  logic                  enable,
    output logic [DATA_WIDTH-1:0] ticks
);

    localparam int unsigned PreW = (TIMEOUT_DIV > 0) ? $clog2(TIMEOUT_DIV + 1) : 1;

    logic [PreW-1:0] prescale;
    logic            tickPulse;

    assign tickPulse = (prescale == PreW'(TIMEOUT_DIV));

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            prescale <= '0;
            ticks    <= '0;
        end else if (clear) begin
            prescale <= '0;
            ticks    <= '0;
        end else if (enable) begin
            if (tickPulse) begin
                prescale <= '0;
                if (ticks != '1) begin
                    ticks <= ticks + DATA_WIDTH'(1);
                end
            end else begin
                prescale <= prescale + PreW'(1);
            end
        end
    end

endmodule

// File: rtl/test_sequencer.sv
// Wishbone classic master that fetches and executes a word-addressed test program,
// reporting pass/fail, an error code and the failing instruction address.
module test_sequencer
    import test_sequencer_pkg::*;
#(
    parameter int unsigned              DATA_WIDTH    = 16,
    parameter int unsigned              ADDRESS_WIDTH = 24,
    parameter logic [ADDRESS_WIDTH-1:0] PROGMEM_START = 'h10000,
    parameter logic [ADDRESS_WIDTH-1:0] PROGMEM_END   = 'h1FFFF,
    parameter logic [ADDRESS_WIDTH-1:0] REGMEM_START  = 'h00000,
    parameter int unsigned              TIMEOUT_DIV   = 0
) (
    input  logic                     clk,
    input  logic                     rstN,
    output logic [ADDRESS_WIDTH-1:0] wbAdrO,
    output logic [DATA_WIDTH-1:0]    wbDatO,
    input  logic [DATA_WIDTH-1:0]    wbDatI,
    output logic                     wbCycO,
    output logic                     wbStbO,
    output logic                     wbWeO,
    input  logic                     wbAckI,
    input  logic                     wbErrI,
    input  logic                     start,
    input  logic                     halt,
    output logic                     busy,
    output logic                     passed,
    output logic                     failed,
    output logic [2:0]               errCode,
    output logic [ADDRESS_WIDTH-1:0] failIp
);

    stateT                    state;
    opcodeT                   opcode;
    logic [ADDRESS_WIDTH-1:0] ip;
    logic [ADDRESS_WIDTH-1:0] curIp;
    logic [DATA_WIDTH-1:0]    op [MaxOperands];
    logic [2:0]               opIdx;
    logic [DATA_WIDTH-1:0]    ticks;

    logic [2:0]               nOps;
    logic [2:0]               fetchedOps;
    logic                     opValid;
    logic                     ipInRange;
    logic                     pollHit;
    logic                     timing;
    logic [ADDRESS_WIDTH-1:0] ipNext;
    logic [ADDRESS_WIDTH-1:0] operandAdr;

    assign nOps       = operandCount(opcode);
    assign fetchedOps = operandCount(opcodeT'(wbDatI[2:0]));
    assign opValid    = (wbDatI != '0) && (wbDatI <= DATA_WIDTH'(7));
    assign ipInRange  = (ip >= PROGMEM_START) && (ip <= PROGMEM_END);
    assign ipNext     = curIp + ADDRESS_WIDTH'(nOps) + ADDRESS_WIDTH'(1);
    assign operandAdr = curIp + ADDRESS_WIDTH'(opIdx) + ADDRESS_WIDTH'(1);
    assign pollHit    = (opcode == OpWaitMask) ? ((wbDatI & op[1]) == op[2])
                                               : ((wbDatI >= op[1]) && (wbDatI <= op[2]));
    assign timing     = (state == StPoll) || (state == StDelay);

    assign busy   = !(state inside {StIdle, StPass, StFail});
    assign passed = (state == StPass);
    assign failed = (state == StFail);

    // Cleared whenever not waiting, so entry into POLL/DELAY always starts from zero.
    timeout_timer #(
        .TIMEOUT_DIV(TIMEOUT_DIV),
        .DATA_WIDTH (DATA_WIDTH)
    ) uTimer (
        .clk   (clk),
        .rstN  (rstN),
        .clear (!timing),
        .enable(timing),
        .ticks (ticks)
    );

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state   <= StIdle;
            opcode  <= OpNone;
            ip      <= PROGMEM_START;
            curIp   <= '0;
            opIdx   <= '0;
            op      <= '{default: '0};
            wbCycO  <= 1'b0;
            wbStbO  <= 1'b0;
            wbWeO   <= 1'b0;
            wbAdrO  <= '0;
            wbDatO  <= '0;
            errCode <= ErrNone;
            failIp  <= '0;
        end else if (halt) begin
            state   <= StIdle;
            opcode  <= OpNone;
            ip      <= PROGMEM_START;
            curIp   <= '0;
            opIdx   <= '0;
            op      <= '{default: '0};
            wbCycO  <= 1'b0;
            wbStbO  <= 1'b0;
            wbWeO   <= 1'b0;
            wbAdrO  <= '0;
            wbDatO  <= '0;
            errCode <= ErrNone;
            failIp  <= '0;
        end else begin
            // Every transfer ends the cycle after ACK/ERR, leaving one idle cycle minimum.
            if (wbCycO && (wbAckI || wbErrI)) begin
                wbCycO <= 1'b0;
                wbStbO <= 1'b0;
                wbWeO  <= 1'b0;
            end
            if (wbCycO && wbErrI) begin
                state   <= StFail;
                errCode <= ErrBus;
                failIp  <= curIp;
            end else begin
                case (state)
                    StIdle: begin
                        if (start) begin
                            state   <= StFetch;
                            ip      <= PROGMEM_START;
                            errCode <= ErrNone;
                            failIp  <= '0;
                        end
                    end
                    StFetch: begin
                        if (!wbCycO) begin
                            if (!ipInRange) begin
                                state   <= StFail;
                                errCode <= ErrRange;
                                failIp  <= ip;
                            end else begin
                                wbCycO <= 1'b1;
                                wbStbO <= 1'b1;
                                wbWeO  <= 1'b0;
                                wbAdrO <= ip;
                                curIp  <= ip;
                            end
                        end else if (wbAckI) begin
                            if (!opValid) begin
                                state   <= StFail;
                                errCode <= ErrOpcode;
                                failIp  <= curIp;
                            end else begin
                                opcode <= opcodeT'(wbDatI[2:0]);
                                opIdx  <= '0;
                                state  <= (fetchedOps == 3'd0) ? StExec : StOperand;
                            end
                        end
                    end
                    StOperand: begin
                        if (!wbCycO) begin
                            wbCycO <= 1'b1;
                            wbStbO <= 1'b1;
                            wbWeO  <= 1'b0;
                            wbAdrO <= operandAdr;
                        end else if (wbAckI) begin
                            op[opIdx[1:0]] <= wbDatI;
                            if (opIdx == nOps - 3'd1) begin
                                state <= StExec;
                            end else begin
                                opIdx <= opIdx + 3'd1;
                            end
                        end
                    end
                    StExec: begin
                        case (opcode)
                            OpSet: begin
                                if (!wbCycO) begin
                                    wbCycO <= 1'b1;
                                    wbStbO <= 1'b1;
                                    wbWeO  <= 1'b1;
                                    wbAdrO <= REGMEM_START + ADDRESS_WIDTH'(op[0]);
                                    wbDatO <= op[1];
                                end else if (wbAckI) begin
                                    ip    <= ipNext;
                                    state <= StFetch;
                                end
                            end
                            OpWait, OpWaitMask: state <= StPoll;
                            OpPause:            state <= StDelay;
                            OpJump: begin
                                ip    <= PROGMEM_START + ADDRESS_WIDTH'(op[0]);
                                state <= StFetch;
                            end
                            OpWin: state <= StPass;
                            OpFail: begin
                                state   <= StFail;
                                errCode <= ErrExplicit;
                                failIp  <= curIp;
                            end
                            default: begin
                                state   <= StFail;
                                errCode <= ErrOpcode;
                                failIp  <= curIp;
                            end
                        endcase
                    end
                    StPoll: begin
                        if (!wbCycO) begin
                            wbCycO <= 1'b1;
                            wbStbO <= 1'b1;
                            wbWeO  <= 1'b0;
                            wbAdrO <= REGMEM_START + ADDRESS_WIDTH'(op[0]);
                        end else if (wbAckI) begin
                            if (pollHit) begin
                                ip    <= ipNext;
                                state <= StFetch;
                            end else if (ticks >= op[3]) begin
                                state   <= StFail;
                                errCode <= ErrTimeout;
                                failIp  <= curIp;
                            end
                        end
                    end
                    StDelay: begin
                        if (ticks >= op[0]) begin
                            ip    <= ipNext;
                            state <= StFetch;
                        end
                    end
                    StPass, StFail: begin
                        if (!start) begin
                            state <= StIdle;
                        end
                    end
                    default: state <= StIdle;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_test_sequencer.sv
// Directed bench for test_sequencer: a Wishbone slave model serves program and register
// accesses while per-scenario tasks check results against hand-derived values.
module tb_test_sequencer;

    logic        clk = 1'b0;
    logic        rstN = 1'b0;
    logic [23:0] wbAdrO;
    logic [15:0] wbDatO;
    logic [15:0] wbDatI = '0;
    logic        wbCycO, wbStbO, wbWeO;
    logic        wbAckI = 1'b0;
    logic        wbErrI = 1'b0;
    logic        start = 1'b0;
    logic        halt = 1'b0;
    logic        busy, passed, failed;
    logic [2:0]  errCode;
    logic [23:0] failIp;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    test_sequencer #(
        .DATA_WIDTH   (16),
        .ADDRESS_WIDTH(24),
        .PROGMEM_START(24'h10000),
        .PROGMEM_END  (24'h1FFFF),
        .REGMEM_START (24'h00000),
        .TIMEOUT_DIV  (3)
    ) dut (
        .clk    (clk),
        .rstN   (rstN),
        .wbAdrO (wbAdrO),
        .wbDatO (wbDatO),
        .wbDatI (wbDatI),
        .wbCycO (wbCycO),
        .wbStbO (wbStbO),
        .wbWeO  (wbWeO),
        .wbAckI (wbAckI),
        .wbErrI (wbErrI),
        .start  (start),
        .halt   (halt),
        .busy   (busy),
        .passed (passed),
        .failed (failed),
        .errCode(errCode),
        .failIp (failIp)
    );

    // Slave model: program words at 0x10000+, register reads served from rdVals (last repeats).
    logic [15:0] prog [0:31];
    logic [15:0] rdVals [0:3];
    int          rdLen = 1;
    int          errAt = 0;
    logic        stallReg = 1'b0;
    int          nFetches = 0, nRegReads = 0, nWrites = 0;
    int          fetchBase = 0, rdBase = 0, wrBase = 0;
    logic [23:0] lastWrAdr = '0;
    logic [15:0] lastWrDat = '0;

    always @(posedge clk) begin
        int idx;
        wbAckI <= 1'b0;
        wbErrI <= 1'b0;
        if (wbCycO && wbStbO && !wbAckI && !wbErrI) begin
            if (wbAdrO >= 24'h10000) begin
                nFetches = nFetches + 1;
                if (nFetches - fetchBase == errAt) begin
                    wbErrI <= 1'b1;
                end else begin
                    wbAckI <= 1'b1;
                    wbDatI <= prog[wbAdrO[4:0]];
                end
            end else if (!stallReg) begin
                if (wbWeO) begin
                    nWrites = nWrites + 1;
                    lastWrAdr <= wbAdrO;
                    lastWrDat <= wbDatO;
                end else begin
                    idx = nRegReads - rdBase;
                    if (idx >= rdLen) idx = rdLen - 1;
                    wbDatI <= rdVals[idx];
                    nRegReads = nRegReads + 1;
                end
                wbAckI <= 1'b1;
            end
        end
    end

    task automatic clearProg();
        for (int i = 0; i < 32; i++) prog[i] = 16'h0;
    endtask

    task automatic startRun();
        fetchBase = nFetches;
        rdBase    = nRegReads;
        wrBase    = nWrites;
        start     = 1'b1;
    endtask

    task automatic waitDone(input int maxCycles, output bit done);
        done = 1'b0;
        for (int i = 0; i < maxCycles; i++) begin
            @(posedge clk);
            #1;
            if (passed || failed) begin
                done = 1'b1;
                break;
            end
        end
    endtask

    task automatic endRun();
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rstN = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({wbCycO, wbStbO, wbWeO, wbAdrO, wbDatO, busy, passed, failed, errCode, failIp} !== '0) begin
            bad++;
            $display("FAIL reset_outputs got cyc=%b adr=%h busy=%b err=%0d failIp=%h want all 0",
                     wbCycO, wbAdrO, busy, errCode, failIp);
        end
        rstN = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (busy !== 1'b0 || wbCycO !== 1'b0) begin
            bad++;
            $display("FAIL idle_no_start got busy=%b cyc=%b want 0 0", busy, wbCycO);
        end
    endtask

    task automatic test_set();
        bit done;
        clearProg();
        prog[0] = 16'd1; prog[1] = 16'd5; prog[2] = 16'hABCD; prog[3] = 16'd4;
        startRun();
        waitDone(200, done);
        total++;
        if (!done || passed !== 1'b1) begin
            bad++;
            $display("FAIL set_pass got passed=%b failed=%b want passed=1", passed, failed);
        end
        total++;
        if (nWrites - wrBase != 1 || lastWrAdr !== 24'h000005 || lastWrDat !== 16'hABCD) begin
            bad++;
            $display("FAIL set_write got n=%0d adr=%h dat=%h want 1 000005 abcd",
                     nWrites - wrBase, lastWrAdr, lastWrDat);
        end
        total++;
        if (busy !== 1'b0 || errCode !== 3'd0) begin
            bad++;
            $display("FAIL set_status got busy=%b err=%0d want 0 0", busy, errCode);
        end
        endRun();
    endtask

    task automatic test_wait();
        bit done;
        clearProg();
        prog[0] = 16'd2; prog[1] = 16'd3; prog[2] = 16'd10; prog[3] = 16'd20; prog[4] = 16'd8;
        prog[5] = 16'd4;
        rdVals[0] = 16'd7; rdVals[1] = 16'd7; rdVals[2] = 16'd15; rdLen = 3;
        startRun();
        waitDone(300, done);
        total++;
        if (!done || passed !== 1'b1) begin
            bad++;
            $display("FAIL wait_pass got passed=%b failed=%b err=%0d want passed=1", passed, failed, errCode);
        end
        total++;
        if (nRegReads - rdBase != 3) begin
            bad++;
            $display("FAIL wait_reads got %0d want 3", nRegReads - rdBase);
        end
        endRun();
    endtask

    task automatic test_wait_timeout();
        bit found;
        int cyc;
        rdVals[0] = 16'd7; rdLen = 1;
        startRun();
        found = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1;
            if (wbCycO && !wbWeO && wbAdrO < 24'h10000) begin
                found = 1'b1;
                break;
            end
        end
        cyc = 0;
        for (int i = 0; i < 100; i++) begin
            if (failed) break;
            @(posedge clk);
            #1;
            cyc++;
        end
        total++;
        if (!found || failed !== 1'b1 || errCode !== 3'd1) begin
            bad++;
            $display("FAIL timeout_status got failed=%b err=%0d want 1 1", failed, errCode);
        end
        total++;
        if (failIp !== 24'h010000) begin
            bad++;
            $display("FAIL timeout_failip got %h want 010000", failIp);
        end
        total++;
        if (cyc < 30 || cyc > 40) begin
            bad++;
            $display("FAIL timeout_latency got %0d clocks want about 36", cyc);
        end
        endRun();
    endtask

    task automatic test_waitmask();
        bit done;
        clearProg();
        prog[0] = 16'd7; prog[1] = 16'd2; prog[2] = 16'h00F0; prog[3] = 16'h0030; prog[4] = 16'd5;
        prog[5] = 16'd4;
        rdVals[0] = 16'h1204; rdVals[1] = 16'hAB3C; rdLen = 2;
        startRun();
        waitDone(300, done);
        total++;
        if (!done || passed !== 1'b1) begin
            bad++;
            $display("FAIL waitmask_pass got passed=%b err=%0d want passed=1", passed, errCode);
        end
        total++;
        if (nRegReads - rdBase != 2) begin
            bad++;
            $display("FAIL waitmask_reads got %0d want 2", nRegReads - rdBase);
        end
        endRun();
    endtask

    task automatic test_pause();
        bit done;
        int gap;
        clearProg();
        prog[0] = 16'd3; prog[1] = 16'd0; prog[2] = 16'd4;
        startRun();
        for (int i = 0; i < 50; i++) begin
            @(posedge clk);
            #1;
            if (wbCycO && wbAdrO == 24'h010001) break;
        end
        for (int i = 0; i < 10; i++) begin
            if (!wbCycO) break;
            @(posedge clk);
            #1;
        end
        gap = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            gap++;
            if (wbCycO && wbAdrO == 24'h010002) break;
        end
        total++;
        if (gap != 3) begin
            bad++;
            $display("FAIL pause_gap got %0d clocks want 3", gap);
        end
        waitDone(50, done);
        total++;
        if (!done || passed !== 1'b1) begin
            bad++;
            $display("FAIL pause_pass got passed=%b want 1", passed);
        end
        endRun();
    endtask

    task automatic test_jump();
        bit done;
        clearProg();
        prog[0] = 16'd6; prog[1] = 16'd5; prog[2] = 16'd9; prog[3] = 16'd9; prog[4] = 16'd9;
        prog[5] = 16'd4;
        startRun();
        waitDone(200, done);
        total++;
        if (!done || passed !== 1'b1) begin
            bad++;
            $display("FAIL jump_pass got passed=%b err=%0d want passed=1", passed, errCode);
        end
        total++;
        if (nFetches - fetchBase != 3) begin
            bad++;
            $display("FAIL jump_fetches got %0d want 3", nFetches - fetchBase);
        end
        endRun();
    endtask

    task automatic test_bad_opcode();
        bit done;
        clearProg();
        prog[0] = 16'h00FF;
        startRun();
        waitDone(100, done);
        total++;
        if (!done || failed !== 1'b1 || errCode !== 3'd2 || failIp !== 24'h010000) begin
            bad++;
            $display("FAIL bad_opcode got failed=%b err=%0d failIp=%h want 1 2 010000",
                     failed, errCode, failIp);
        end
        endRun();
    endtask

    task automatic test_bus_error();
        bit done;
        clearProg();
        prog[0] = 16'd1; prog[1] = 16'd5; prog[2] = 16'hABCD; prog[3] = 16'd4;
        errAt = 2;
        startRun();
        waitDone(100, done);
        total++;
        if (!done || failed !== 1'b1 || errCode !== 3'd3) begin
            bad++;
            $display("FAIL bus_error got failed=%b err=%0d want 1 3", failed, errCode);
        end
        total++;
        if (failIp !== 24'h010000 || nWrites - wrBase != 0) begin
            bad++;
            $display("FAIL bus_error_ip got failIp=%h writes=%0d want 010000 0",
                     failIp, nWrites - wrBase);
        end
        errAt = 0;
        endRun();
        total++;
        if (errCode !== 3'd3 || passed !== 1'b0 || failed !== 1'b0) begin
            bad++;
            $display("FAIL err_held got err=%0d passed=%b failed=%b want 3 0 0", errCode, passed, failed);
        end
    endtask

    task automatic test_halt();
        bit found;
        clearProg();
        prog[0] = 16'd2; prog[1] = 16'd3; prog[2] = 16'd10; prog[3] = 16'd20; prog[4] = 16'd8;
        prog[5] = 16'd4;
        stallReg = 1'b1;
        startRun();
        found = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1;
            if (wbCycO && wbAdrO == 24'h000003) begin
                found = 1'b1;
                break;
            end
        end
        halt  = 1'b1;
        start = 1'b0;
        @(posedge clk);
        #1;
        total++;
        if (!found || {wbCycO, wbStbO, wbWeO, wbAdrO, wbDatO, busy, passed, failed, errCode, failIp} !== '0) begin
            bad++;
            $display("FAIL halt_outputs got found=%b cyc=%b busy=%b adr=%h err=%0d want all 0",
                     found, wbCycO, busy, wbAdrO, errCode);
        end
        stallReg = 1'b0;
        halt     = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (wbCycO !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL halt_stays_idle got cyc=%b busy=%b want 0 0", wbCycO, busy);
        end
    endtask

    task automatic test_async_reset();
        bit found;
        bit done;
        clearProg();
        prog[0] = 16'd1; prog[1] = 16'd5; prog[2] = 16'hABCD; prog[3] = 16'd4;
        stallReg = 1'b1;
        startRun();
        found = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1;
            if (wbCycO && wbWeO) begin
                found = 1'b1;
                break;
            end
        end
        #2;
        rstN = 1'b0;
        #1;
        total++;
        if (!found || {wbCycO, wbStbO, wbWeO, wbAdrO, wbDatO, busy, passed, failed, errCode, failIp} !== '0) begin
            bad++;
            $display("FAIL async_reset got found=%b cyc=%b we=%b adr=%h busy=%b want all 0",
                     found, wbCycO, wbWeO, wbAdrO, busy);
        end
        stallReg = 1'b0;
        start    = 1'b0;
        @(posedge clk);
        #1;
        rstN = 1'b1;
        @(posedge clk);
        #1;
        startRun();
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (wbCycO) begin
                found = 1'b1;
                break;
            end
        end
        total++;
        if (!found || wbAdrO !== 24'h010000 || wbWeO !== 1'b0) begin
            bad++;
            $display("FAIL restart_fetch got found=%b adr=%h we=%b want 1 010000 0", found, wbAdrO, wbWeO);
        end
        waitDone(200, done);
        total++;
        if (!done || passed !== 1'b1) begin
            bad++;
            $display("FAIL restart_pass got passed=%b failed=%b want passed=1", passed, failed);
        end
        endRun();
    endtask

    initial begin
        test_reset();
        test_set();
        test_wait();
        test_wait_timeout();
        test_waitmask();
        test_pause();
        test_jump();
        test_bad_opcode();
        test_bus_error();
        test_halt();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
